// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES encryption controller.
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int NR_128  = 10;
   localparam int NR_192  = 12;
   localparam int NR_256  = 14;

   typedef enum logic [1:0] {
      IDLE,
      KEY0,
      ROUND,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: initial AddRoundKey, then NR passes through a shared round datapath.
// Optional feature: define AES_CTRL_ABORT_EN to add an abort input that returns the block to IDLE.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR   = NR_128,
   parameter int RK_W = 4
) (
   input  logic                clk,
   input  logic                rst,
`ifdef AES_CTRL_ABORT_EN
   input  logic                abort,
`endif
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BLOCK_W-1:0]  in_block,
   output logic                rk_req,
   output logic [RK_W-1:0]     rk_idx,
   input  logic                rk_valid,
   input  logic [BLOCK_W-1:0]  rk_data,
   output logic [BLOCK_W-1:0]  dp_state,
   output logic [BLOCK_W-1:0]  dp_key,
   output logic                dp_last,
   input  logic [BLOCK_W-1:0]  dp_result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLOCK_W-1:0]  out_block
);

   ctrl_state_t        cur;
   ctrl_state_t        nxt;
   logic [RK_W-1:0]    round;
   logic [RK_W-1:0]    round_nxt;
   logic [BLOCK_W-1:0] state_q;
   logic [BLOCK_W-1:0] state_nxt;
   logic               last_round;

   assign last_round = (round == RK_W'(NR));
   assign dp_state   = state_q;
   assign dp_key     = rk_data;
   assign out_block  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= IDLE;
         round   <= '0;
         state_q <= '0;
      end else begin
         cur     <= nxt;
         round   <= round_nxt;
         state_q <= state_nxt;
      end
   end

   always_comb begin
      nxt       = cur;
      round_nxt = round;
      state_nxt = state_q;
      in_ready  = 1'b0;
      rk_req    = 1'b0;
      rk_idx    = '0;
      dp_last   = 1'b0;
      out_valid = 1'b0;

      case (cur)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = in_block;
               nxt       = KEY0;
            end
         end
         KEY0: begin
            rk_req = 1'b1;
            if (rk_valid) begin
               state_nxt = state_q ^ rk_data;
               round_nxt = RK_W'(1);
               nxt       = ROUND;
            end
         end
         ROUND: begin
            rk_req  = 1'b1;
            rk_idx  = round;
            dp_last = last_round;
            // A missing key stalls the round: state and counter simply hold.
            if (rk_valid) begin
               state_nxt = dp_result;
               if (last_round) begin
                  nxt = DONE;
               end else begin
                  round_nxt = round + RK_W'(1);
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               nxt       = IDLE;
               round_nxt = '0;
            end
         end
         default: nxt = IDLE;
      endcase

`ifdef AES_CTRL_ABORT_EN
      // Abort outranks key arrival and the output handshake; the partial block is cleared.
      if (abort && (cur != IDLE)) begin
         nxt       = IDLE;
         round_nxt = '0;
         state_nxt = '0;
         out_valid = 1'b0;
      end
`endif
   end

endmodule
